// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the streaming GCD engine.
//
// Contents:
//   gcd_state_e    - controller state encoding (IDLE / CALC / DONE, 2 bits)
//   GCD_WIDTH_DEF  - default operand/result width
//   GCD_CNT_W_DEF  - default width of the optional CALC-cycle counter
//
// Optional feature macro used by the engine: GCD_CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
package gcd_pkg;

   // Controller states. IDLE waits for operands, CALC runs one Euclid
   // subtraction step per clock, DONE holds the result until it is taken.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } gcd_state_e;

   localparam int GCD_WIDTH_DEF = 32;
   localparam int GCD_CNT_W_DEF = 32;

endpackage : gcd_pkg

// File: rtl/gcd_step.sv
// ---------------------------------------------------------------------------
// gcd_step
// Combinational datapath for a single subtractive-Euclid step. Holds no
// state; the parent registers next_a/next_b or captures result.
//
// Ports:
//   a, b        in   WIDTH  current working operands
//   next_a      out  WIDTH  operand A after this step
//   next_b      out  WIDTH  operand B after this step
//   term        out  1      this step finishes the computation
//   result      out  WIDTH  GCD value, meaningful only when term=1
// ---------------------------------------------------------------------------
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] next_a,
   output logic [WIDTH-1:0] next_b,
   output logic             term,
   output logic [WIDTH-1:0] result
);

   // Decisions are checked in a fixed priority: a zero operand or equal
   // operands end the computation; otherwise the larger operand has the
   // smaller one subtracted from it, so the difference can never wrap.
   always_comb begin
      next_a = a;
      next_b = b;
      term   = 1'b0;
      result = a;
      if (a == '0) begin
         term   = 1'b1;
         result = b;
      end else if (b == '0) begin
         term   = 1'b1;
         result = a;
      end else if (a == b) begin
         term   = 1'b1;
         result = a;
      end else if (a > b) begin
         next_a = a - b;
      end else begin
         next_b = b - a;
      end
   end

endmodule : gcd_step

// File: rtl/gcd_stream.sv
// ---------------------------------------------------------------------------
// gcd_stream
// Streaming GCD engine: accepts an operand pair over a valid/ready
// handshake, iterates subtractive Euclid one step per clock, and presents
// the result over a second valid/ready handshake, holding it under
// backpressure. One operation is in flight at a time.
//
// Optional feature: define GCD_CYCLE_COUNT_EN to add the out_cycles port,
// which reports how many CALC cycles the last operation took (saturating).
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous active-high reset
//   in_valid    in   1      operand pair valid
//   in_ready    out  1      engine idle and able to accept operands
//   in_a        in   WIDTH  operand A (unsigned)
//   in_b        in   WIDTH  operand B (unsigned)
//   out_valid   out  1      result valid
//   out_ready   in   1      consumer takes the result
//   out_gcd     out  WIDTH  GCD result (left stale after hand-off)
//   out_cycles  out  CNT_W  CALC cycles used (GCD_CYCLE_COUNT_EN only)
// ---------------------------------------------------------------------------
module gcd_stream
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEF,
   parameter int CNT_W = GCD_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef GCD_CYCLE_COUNT_EN
   output logic [WIDTH-1:0] out_gcd,
   output logic [CNT_W-1:0] out_cycles
`else
   output logic [WIDTH-1:0] out_gcd
`endif
);

   // Reject nonsensical parameterisations at elaboration time.
   if (WIDTH < 2 || CNT_W < 1) begin : gBadParams
      $error("gcd_stream: WIDTH must be >= 2 and CNT_W >= 1");
   end

   gcd_state_e       state_q;
   logic [WIDTH-1:0] tempA_q;
   logic [WIDTH-1:0] tempB_q;
   logic [WIDTH-1:0] gcd_q;
   logic             valid_q;

   logic [WIDTH-1:0] nextA_d;
   logic [WIDTH-1:0] nextB_d;
   logic             stepTerm;
   logic [WIDTH-1:0] stepResult;

   // One step datapath evaluates the current working pair every cycle;
   // the controller below decides whether to use its outputs.
   gcd_step #(
      .WIDTH (WIDTH)
   ) uStep (
      .a      (tempA_q),
      .b      (tempB_q),
      .next_a (nextA_d),
      .next_b (nextB_d),
      .term   (stepTerm),
      .result (stepResult)
   );

`ifdef GCD_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cycles_q;
   logic [CNT_W-1:0] cnt_d;

   // Running CALC-cycle count, stuck at all-ones once it saturates so a
   // very long operation never reports a small wrapped-around value.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign out_cycles = cycles_q;
`endif

   // Handshake outputs: in_ready is a pure decode of the state so the
   // source sees it without extra delay; out_valid is its own register.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = valid_q;
   assign out_gcd   = gcd_q;

   // Main controller. IDLE loads operands on a handshake, CALC either
   // advances the working pair or captures the result on the terminating
   // step, and DONE holds the result until the consumer takes it. The
   // result register is deliberately not cleared on hand-off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tempA_q  <= '0;
         tempB_q  <= '0;
         gcd_q    <= '0;
         valid_q  <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
         cnt_q    <= '0;
         cycles_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  tempA_q <= in_a;
                  tempB_q <= in_b;
                  state_q <= CALC;
`ifdef GCD_CYCLE_COUNT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
               cnt_q <= cnt_d;
`endif
               if (stepTerm) begin
                  gcd_q    <= stepResult;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
`ifdef GCD_CYCLE_COUNT_EN
                  cycles_q <= cnt_d;
`endif
               end else begin
                  tempA_q <= nextA_d;
                  tempB_q <= nextB_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule : gcd_stream

// File: tb/tb_gcd_stream.sv
// ---------------------------------------------------------------------------
// tb_gcd_stream
// Directed self-checking bench for gcd_stream. Checks out_cycles as well
// when built with GCD_CYCLE_COUNT_EN defined.
// ---------------------------------------------------------------------------
module tb_gcd_stream;

   localparam int WIDTH = 32;
   localparam int CNT_W = 32;
   localparam int NSTREAM = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_gcd;
`ifdef GCD_CYCLE_COUNT_EN
   logic [CNT_W-1:0] out_cycles;
`endif

   int checks = 0;
   int errors = 0;

   gcd_stream #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef GCD_CYCLE_COUNT_EN
      .out_gcd    (out_gcd),
      .out_cycles (out_cycles)
`else
      .out_gcd    (out_gcd)
`endif
   );

   // 10 time-unit clock period.
   always #5 clk = ~clk;

   // Reference GCD using the remainder form of Euclid.
   function automatic logic [63:0] swGcd(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operand pair for exactly one edge; the engine must be idle.
   task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      checkOutput({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checkOutput({tag, " in_ready after accept"}, 64'(in_ready), 64'd0);
   endtask

   // Full operation: accept, measure edges until out_valid, check result
   // and (when out_ready is high) the hand-off back to IDLE.
   task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [63:0] expGcd, input logic [63:0] expCycles);
      int lat;
      applyStimulus(tag, a, b);
      lat = 1;
      tick();
      while (!out_valid && lat < 2000) begin
         tick();
         lat++;
      end
      checkOutput({tag, " latency"}, 64'(lat), expCycles);
      checkOutput({tag, " out_gcd"}, 64'(out_gcd), expGcd);
`ifdef GCD_CYCLE_COUNT_EN
      checkOutput({tag, " out_cycles"}, 64'(out_cycles), expCycles);
`endif
      if (out_ready) begin
         checkOutput({tag, " in_ready while DONE"}, 64'(in_ready), 64'd0);
         tick();
         checkOutput({tag, " out_valid after handoff"}, 64'(out_valid), 64'd0);
         checkOutput({tag, " in_ready after handoff"}, 64'(in_ready), 64'd1);
      end
   endtask

   logic [WIDTH-1:0] pa [NSTREAM];
   logic [WIDTH-1:0] pb [NSTREAM];

   initial begin
      int  inIdx;
      int  outIdx;
      int  cyc;
      logic inFire;
      logic outFire;
      logic [WIDTH-1:0] obs;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      // Reset state.
      #12;
      checkOutput("reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset out_gcd", 64'(out_gcd), 64'd0);
`ifdef GCD_CYCLE_COUNT_EN
      checkOutput("reset out_cycles", 64'(out_cycles), 64'd0);
`endif
      tick();
      rst = 1'b0;

      // Basic operations with an always-ready consumer.
      runOp("op56_98", 32'd56, 32'd98, 64'd14, 64'd5);
      runOp("op48_18", 32'd48, 32'd18, 64'd6, 64'd5);

      // Long operation followed by consumer backpressure while a new pair waits.
      out_ready = 1'b0;
      runOp("op101_103", 32'd101, 32'd103, 64'd1, 64'd53);
      in_a     = 32'd5;
      in_b     = 32'd10;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("hold out_valid", 64'(out_valid), 64'd1);
         checkOutput("hold out_gcd", 64'(out_gcd), 64'd1);
         checkOutput("hold in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checkOutput("release out_valid", 64'(out_valid), 64'd0);
      checkOutput("release in_ready", 64'(in_ready), 64'd1);
      checkOutput("release stale out_gcd", 64'(out_gcd), 64'd1);

      // Degenerate operands, each finishing in a single CALC cycle.
      runOp("op0_0", 32'd0, 32'd0, 64'd0, 64'd1);
      runOp("op0_77", 32'd0, 32'd77, 64'd77, 64'd1);
      runOp("op77_0", 32'd77, 32'd0, 64'd77, 64'd1);
      runOp("op77_77", 32'd77, 32'd77, 64'd77, 64'd1);

      // Back-to-back stream with in_valid held and a random consumer.
      pa[0] = 32'd12; pb[0] = 32'd8;
      pa[1] = 32'd35; pb[1] = 32'd14;
      pa[2] = 32'd9;  pb[2] = 32'd28;
      pa[3] = 32'd20; pb[3] = 32'd20;
      pa[4] = 32'd0;  pb[4] = 32'd5;
      pa[5] = 32'd81; pb[5] = 32'd27;
      inIdx  = 0;
      outIdx = 0;
      cyc    = 0;
      while (outIdx < NSTREAM && cyc < 5000) begin
         if (inIdx < NSTREAM) begin
            in_valid = 1'b1;
            in_a     = pa[inIdx];
            in_b     = pb[inIdx];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         inFire  = in_valid && in_ready;
         outFire = out_valid && out_ready;
         obs     = out_gcd;
         tick();
         if (inFire) inIdx++;
         if (outFire) begin
            checkOutput("stream result", 64'(obs), swGcd(64'(pa[outIdx]), 64'(pb[outIdx])));
            outIdx++;
         end
         cyc++;
      end
      checkOutput("stream results drained", 64'(outIdx), 64'(NSTREAM));
      checkOutput("stream inputs accepted", 64'(inIdx), 64'(NSTREAM));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checkOutput("stream no duplicate", 64'(out_valid), 64'd0);
      checkOutput("stream idle", 64'(in_ready), 64'd1);

      // Reset in the middle of a long computation discards it.
      applyStimulus("midreset", 32'd101, 32'd103);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("midreset calc out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset calc in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      #1;
      checkOutput("midreset in_ready", 64'(in_ready), 64'd1);
      checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset out_gcd", 64'(out_gcd), 64'd0);
`ifdef GCD_CYCLE_COUNT_EN
      checkOutput("midreset out_cycles", 64'(out_cycles), 64'd0);
`endif
      tick();
      rst = 1'b0;
      runOp("after_reset48_18", 32'd48, 32'd18, 64'd6, 64'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_gcd_stream
